// File: rtl/position_ledger_if.sv
`default_nettype none
// position_ledger_if: update, query, report and status bundle for position_ledger.
// The master side drives updates and queries; the slave side (the ledger) returns reports and status.
interface position_ledger_if #(
    parameter int SYMBOL_WIDTH = 32,
    parameter int VOLUME_WIDTH = 32,
    parameter int POS_WIDTH    = 48,
    parameter int NUM_SLOTS    = 16,
    parameter int SLOT_W       = $clog2(NUM_SLOTS)
);
    logic                    upd_valid;
    logic [SYMBOL_WIDTH-1:0] upd_symbol;
    logic [VOLUME_WIDTH-1:0] upd_quantity;
    logic                    upd_side;
    logic [POS_WIDTH-2:0]    pos_limit;
    logic                    clear;
    logic                    qry_valid;
    logic [SYMBOL_WIDTH-1:0] qry_symbol;
    logic                    qry_resp_valid;
    logic                    qry_found;
    logic [POS_WIDTH-1:0]    qry_position;
    logic                    rpt_valid;
    logic [SYMBOL_WIDTH-1:0] rpt_symbol;
    logic [POS_WIDTH-1:0]    rpt_position;
    logic [SLOT_W-1:0]       rpt_slot;
    logic                    rpt_breach;
    logic                    table_full;
    logic [SLOT_W:0]         used_slots;
    logic [31:0]             drop_count;
    logic [31:0]             breach_count;

    modport master (
        output upd_valid, upd_symbol, upd_quantity, upd_side, pos_limit, clear,
               qry_valid, qry_symbol,
        input  qry_resp_valid, qry_found, qry_position, rpt_valid, rpt_symbol,
               rpt_position, rpt_slot, rpt_breach, table_full, used_slots,
               drop_count, breach_count
    );

    modport slave (
        input  upd_valid, upd_symbol, upd_quantity, upd_side, pos_limit, clear,
               qry_valid, qry_symbol,
        output qry_resp_valid, qry_found, qry_position, rpt_valid, rpt_symbol,
               rpt_position, rpt_slot, rpt_breach, table_full, used_slots,
               drop_count, breach_count
    );
endinterface
`default_nettype wire

// File: rtl/position_ledger.sv
`default_nettype none
// position_ledger: per-symbol saturating net-position table with a registered update report and query port.
// Optional POSITION_LEDGER_ZERO_RECLAIM_EN frees a slot whose position returns to exactly zero on a hit.
module position_ledger #(
    parameter int SYMBOL_WIDTH = 32,
    parameter int VOLUME_WIDTH = 32,
    parameter int POS_WIDTH    = 48,
    parameter int NUM_SLOTS    = 16,
    parameter int SLOT_W       = $clog2(NUM_SLOTS)
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    position_ledger_if.slave bus
);
    localparam int EXT_W = ((POS_WIDTH > VOLUME_WIDTH) ? POS_WIDTH : VOLUME_WIDTH) + 2;
    localparam logic signed [EXT_W-1:0] C_POS_MAX =
        {{(EXT_W-POS_WIDTH+1){1'b0}}, {(POS_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] C_NEG_MAX = -C_POS_MAX;

    logic [NUM_SLOTS-1:0]    valid_q;
    logic [SYMBOL_WIDTH-1:0] sym_q [NUM_SLOTS];
    logic [POS_WIDTH-1:0]    pos_q [NUM_SLOTS];

    logic                    s1_valid_q;
    logic [SYMBOL_WIDTH-1:0] s1_symbol_q;
    logic [VOLUME_WIDTH-1:0] s1_qty_q;
    logic                    s1_side_q;

    logic                    rpt_valid_q, rpt_breach_q;
    logic [SYMBOL_WIDTH-1:0] rpt_symbol_q;
    logic [POS_WIDTH-1:0]    rpt_position_q;
    logic [SLOT_W-1:0]       rpt_slot_q;
    logic                    qry_resp_valid_q, qry_found_q;
    logic [POS_WIDTH-1:0]    qry_position_q;
    logic [SLOT_W:0]         used_q, used_d;
    logic                    table_full_q;
    logic [31:0]             drop_q, breach_cnt_q;

    logic                    hit, free_ok, write_en, drop, alloc, reclaim, breach;
    logic [SLOT_W-1:0]       hit_idx, free_idx, wr_idx;
    logic [POS_WIDTH-1:0]    base, new_pos, abs_pos;
    logic signed [EXT_W-1:0] base_ext, qty_ext, sum;
    logic                    q_found;
    logic [POS_WIDTH-1:0]    q_pos;

    // Descending scan leaves the lowest-index free slot in free_idx.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free_ok  = 1'b0;
        free_idx = '0;
        q_found  = 1'b0;
        q_pos    = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (valid_q[i] && (sym_q[i] == s1_symbol_q)) begin
                hit     = 1'b1;
                hit_idx = SLOT_W'(i);
            end
            if (!valid_q[i]) begin
                free_ok  = 1'b1;
                free_idx = SLOT_W'(i);
            end
            if (valid_q[i] && (sym_q[i] == bus.qry_symbol)) begin
                q_found = 1'b1;
                q_pos   = pos_q[i];
            end
        end
    end

    always_comb begin
        base     = hit ? pos_q[hit_idx] : '0;
        base_ext = {{(EXT_W-POS_WIDTH){base[POS_WIDTH-1]}}, base};
        qty_ext  = {{(EXT_W-VOLUME_WIDTH){1'b0}}, s1_qty_q};
        sum      = s1_side_q ? (base_ext - qty_ext) : (base_ext + qty_ext);
        if (sum > C_POS_MAX) begin
            new_pos = C_POS_MAX[POS_WIDTH-1:0];
        end else if (sum < C_NEG_MAX) begin
            new_pos = C_NEG_MAX[POS_WIDTH-1:0];
        end else begin
            new_pos = sum[POS_WIDTH-1:0];
        end
        abs_pos  = new_pos[POS_WIDTH-1] ? (~new_pos + 1'b1) : new_pos;
        breach   = abs_pos > {1'b0, bus.pos_limit};
        write_en = s1_valid_q && (hit || free_ok) && !bus.clear;
        drop     = s1_valid_q && !hit && !free_ok && !bus.clear;
        wr_idx   = hit ? hit_idx : free_idx;
        alloc    = write_en && !hit;
`ifdef POSITION_LEDGER_ZERO_RECLAIM_EN
        reclaim  = write_en && hit && (new_pos == '0);
`else
        reclaim  = 1'b0;
`endif
        used_d   = used_q + {{SLOT_W{1'b0}}, alloc} - {{SLOT_W{1'b0}}, reclaim};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                sym_q[i] <= '0;
                pos_q[i] <= '0;
            end
        end else if (bus.clear) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                pos_q[i] <= '0;
            end
        end else if (write_en) begin
            valid_q[wr_idx] <= !reclaim;
            sym_q[wr_idx]   <= s1_symbol_q;
            pos_q[wr_idx]   <= new_pos;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_symbol_q <= '0;
            s1_qty_q    <= '0;
            s1_side_q   <= 1'b0;
        end else begin
            s1_valid_q <= bus.upd_valid && !bus.clear;
            if (bus.upd_valid) begin
                s1_symbol_q <= bus.upd_symbol;
                s1_qty_q    <= bus.upd_quantity;
                s1_side_q   <= bus.upd_side;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_valid_q      <= 1'b0;
            rpt_symbol_q     <= '0;
            rpt_position_q   <= '0;
            rpt_slot_q       <= '0;
            rpt_breach_q     <= 1'b0;
            qry_resp_valid_q <= 1'b0;
            qry_found_q      <= 1'b0;
            qry_position_q   <= '0;
            used_q           <= '0;
            table_full_q     <= 1'b0;
            drop_q           <= '0;
            breach_cnt_q     <= '0;
        end else if (bus.clear) begin
            rpt_valid_q      <= 1'b0;
            qry_resp_valid_q <= 1'b0;
            used_q           <= '0;
            table_full_q     <= 1'b0;
        end else begin
            rpt_valid_q      <= write_en;
            qry_resp_valid_q <= bus.qry_valid;
            used_q           <= used_d;
            table_full_q     <= (used_d == (SLOT_W+1)'(NUM_SLOTS));
            if (write_en) begin
                rpt_symbol_q   <= s1_symbol_q;
                rpt_position_q <= new_pos;
                rpt_slot_q     <= wr_idx;
                rpt_breach_q   <= breach;
            end
            if (bus.qry_valid) begin
                qry_found_q    <= q_found;
                qry_position_q <= q_pos;
            end
            if (drop && (drop_q != 32'hFFFF_FFFF)) begin
                drop_q <= drop_q + 32'd1;
            end
            if (write_en && breach && (breach_cnt_q != 32'hFFFF_FFFF)) begin
                breach_cnt_q <= breach_cnt_q + 32'd1;
            end
        end
    end

    assign bus.rpt_valid      = rpt_valid_q;
    assign bus.rpt_symbol     = rpt_symbol_q;
    assign bus.rpt_position   = rpt_position_q;
    assign bus.rpt_slot       = rpt_slot_q;
    assign bus.rpt_breach     = rpt_breach_q;
    assign bus.qry_resp_valid = qry_resp_valid_q;
    assign bus.qry_found      = qry_found_q;
    assign bus.qry_position   = qry_position_q;
    assign bus.used_slots     = used_q;
    assign bus.table_full     = table_full_q;
    assign bus.drop_count     = drop_q;
    assign bus.breach_count   = breach_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_position_ledger.sv
`default_nettype none
// tb_position_ledger: directed scenarios plus randomized traffic checked against a slot-table reference model.
module tb_position_ledger;
    localparam int  SW   = 16;
    localparam int  VW   = 16;
    localparam int  PW   = 16;
    localparam int  NS   = 4;
    localparam int  SLW  = 2;
    localparam longint PMAX = 32767;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    position_ledger_if #(.SYMBOL_WIDTH(SW), .VOLUME_WIDTH(VW), .POS_WIDTH(PW),
                         .NUM_SLOTS(NS), .SLOT_W(SLW)) bus ();

    position_ledger #(.SYMBOL_WIDTH(SW), .VOLUME_WIDTH(VW), .POS_WIDTH(PW),
                      .NUM_SLOTS(NS), .SLOT_W(SLW)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: a plain slot table of (valid, symbol, integer position).
    bit          m_val [NS];
    logic [15:0] m_sym [NS];
    longint      m_pos [NS];
    bit          m_s1v;
    logic [15:0] m_s1sym;
    longint      m_s1qty;
    bit          m_s1side;
    int          m_used;
    longint      m_drop, m_brc;
    bit          exp_rv, exp_rbr, exp_qv, exp_qf;
    logic [15:0] exp_rsym;
    longint      exp_rpos, exp_qp;
    int          exp_rslot;

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_val[i] = 0; m_sym[i] = '0; m_pos[i] = 0;
        end
        m_s1v = 0; m_used = 0; m_drop = 0; m_brc = 0;
        exp_rv = 0; exp_qv = 0;
    endtask

    task automatic model_edge();
        int hi, fi, s;
        longint nv, lim;
        exp_rv = 0;
        exp_qv = 0;
        if (bus.clear) begin
            for (int i = 0; i < NS; i++) begin
                m_val[i] = 0; m_pos[i] = 0;
            end
            m_s1v = 0;
        end else begin
            if (bus.qry_valid) begin
                exp_qv = 1; exp_qf = 0; exp_qp = 0;
                for (int i = 0; i < NS; i++)
                    if (m_val[i] && m_sym[i] == bus.qry_symbol) begin
                        exp_qf = 1; exp_qp = m_pos[i];
                    end
            end
            if (m_s1v) begin
                hi = -1; fi = -1;
                for (int i = 0; i < NS; i++) begin
                    if (m_val[i] && m_sym[i] == m_s1sym) hi = i;
                    if (!m_val[i] && fi < 0) fi = i;
                end
                if (hi < 0 && fi < 0) begin
                    if (m_drop != 64'hFFFF_FFFF) m_drop++;
                end else begin
                    s  = (hi >= 0) ? hi : fi;
                    nv = (hi >= 0) ? m_pos[hi] : 0;
                    nv = m_s1side ? nv - m_s1qty : nv + m_s1qty;
                    if (nv > PMAX)  nv = PMAX;
                    if (nv < -PMAX) nv = -PMAX;
                    m_val[s] = 1; m_sym[s] = m_s1sym; m_pos[s] = nv;
`ifdef POSITION_LEDGER_ZERO_RECLAIM_EN
                    if (hi >= 0 && nv == 0) m_val[s] = 0;
`endif
                    lim = longint'(bus.pos_limit);
                    exp_rv = 1; exp_rsym = m_s1sym; exp_rpos = nv; exp_rslot = s;
                    exp_rbr = (nv > lim) || (-nv > lim);
                    if (exp_rbr && m_brc != 64'hFFFF_FFFF) m_brc++;
                end
            end
            m_s1v    = bus.upd_valid;
            m_s1sym  = bus.upd_symbol;
            m_s1qty  = longint'(bus.upd_quantity);
            m_s1side = bus.upd_side;
        end
        m_used = 0;
        for (int i = 0; i < NS; i++) if (m_val[i]) m_used++;
    endtask

    task automatic step(input bit uv, input logic [15:0] us, input int uq, input bit sd,
                        input bit qv, input logic [15:0] qs, input bit clr);
        bus.upd_valid = uv; bus.upd_symbol = us; bus.upd_quantity = 16'(uq); bus.upd_side = sd;
        bus.qry_valid = qv; bus.qry_symbol = qs; bus.clear = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        bus.upd_valid = 0; bus.upd_symbol = '0; bus.upd_quantity = '0; bus.upd_side = 0;
        bus.qry_valid = 0; bus.qry_symbol = '0; bus.clear = 0; bus.pos_limit = 15'd1000;
        rst_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #1;
        n_checks += 12;
        if (bus.rpt_valid !== 1'b0)      begin n_err++; $display("FAIL reset rpt_valid got=%b want=0", bus.rpt_valid); end
        if (bus.rpt_symbol !== '0)       begin n_err++; $display("FAIL reset rpt_symbol got=%h want=0", bus.rpt_symbol); end
        if (bus.rpt_position !== '0)     begin n_err++; $display("FAIL reset rpt_position got=%h want=0", bus.rpt_position); end
        if (bus.rpt_slot !== '0)         begin n_err++; $display("FAIL reset rpt_slot got=%h want=0", bus.rpt_slot); end
        if (bus.rpt_breach !== 1'b0)     begin n_err++; $display("FAIL reset rpt_breach got=%b want=0", bus.rpt_breach); end
        if (bus.qry_resp_valid !== 1'b0) begin n_err++; $display("FAIL reset qry_resp_valid got=%b want=0", bus.qry_resp_valid); end
        if (bus.qry_found !== 1'b0)      begin n_err++; $display("FAIL reset qry_found got=%b want=0", bus.qry_found); end
        if (bus.qry_position !== '0)     begin n_err++; $display("FAIL reset qry_position got=%h want=0", bus.qry_position); end
        if (bus.table_full !== 1'b0)     begin n_err++; $display("FAIL reset table_full got=%b want=0", bus.table_full); end
        if (bus.used_slots !== '0)       begin n_err++; $display("FAIL reset used_slots got=%0d want=0", bus.used_slots); end
        if (bus.drop_count !== '0)       begin n_err++; $display("FAIL reset drop_count got=%0d want=0", bus.drop_count); end
        if (bus.breach_count !== '0)     begin n_err++; $display("FAIL reset breach_count got=%0d want=0", bus.breach_count); end
    endtask

    task automatic test_accumulation();
        int qty [5] = '{100, 50, 30, 0, 0};
        bit sd  [5] = '{0, 0, 1, 0, 0};
        longint want [3] = '{100, 150, 120};
        int k = 0;
        for (int c = 0; c < 5; c++) begin
            step(c < 3, 16'h00A1, qty[c], sd[c], 0, '0, 0);
            n_checks++;
            if (bus.rpt_valid !== exp_rv) begin n_err++; $display("FAIL accum rpt_valid cyc=%0d got=%b want=%b", c, bus.rpt_valid, exp_rv); end
            if (exp_rv) begin
                n_checks += 3;
                if (bus.rpt_position !== 16'(want[k])) begin n_err++; $display("FAIL accum position got=%0d want=%0d", $signed(bus.rpt_position), want[k]); end
                if (bus.rpt_slot !== 2'd0) begin n_err++; $display("FAIL accum rpt_slot got=%0d want=0", bus.rpt_slot); end
                if (bus.rpt_position !== 16'(exp_rpos)) begin n_err++; $display("FAIL accum model_pos got=%0d want=%0d", $signed(bus.rpt_position), exp_rpos); end
                k++;
            end
        end
        n_checks += 2;
        if (k != 3) begin n_err++; $display("FAIL accum report_count got=%0d want=3", k); end
        if (bus.used_slots !== 3'd1) begin n_err++; $display("FAIL accum used_slots got=%0d want=1", bus.used_slots); end
    endtask

    task automatic test_query_timing();
        step(1, 16'h00A1, 50, 0, 0, '0, 0);
        step(0, '0, 0, 0, 1, 16'h00A1, 0);
        n_checks += 2;
        if (bus.qry_resp_valid !== 1'b1 || bus.qry_found !== 1'b1) begin n_err++; $display("FAIL qry_same_edge valid/found got=%b/%b want=1/1", bus.qry_resp_valid, bus.qry_found); end
        if (bus.qry_position !== 16'd120) begin n_err++; $display("FAIL qry_same_edge position got=%0d want=120", $signed(bus.qry_position)); end
        step(0, '0, 0, 0, 1, 16'h00A1, 0);
        n_checks++;
        if (bus.qry_position !== 16'd170) begin n_err++; $display("FAIL qry_next_edge position got=%0d want=170", $signed(bus.qry_position)); end
        step(0, '0, 0, 0, 1, 16'h0077, 0);
        n_checks += 2;
        if (bus.qry_found !== 1'b0) begin n_err++; $display("FAIL qry_absent found got=%b want=0", bus.qry_found); end
        if (bus.qry_position !== '0) begin n_err++; $display("FAIL qry_absent position got=%0d want=0", $signed(bus.qry_position)); end
        step(0, '0, 0, 0, 0, '0, 0);
        n_checks++;
        if (bus.qry_resp_valid !== 1'b0) begin n_err++; $display("FAIL qry_idle resp_valid got=%b want=0", bus.qry_resp_valid); end
    endtask

    task automatic test_table_full();
        logic [15:0] syms [8] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd2, 16'd0};
        int          qtys [8] = '{10, 10, 10, 10, 10, 0, 7, 0};
        longint drop0;
        step(0, '0, 0, 0, 0, '0, 1);
        drop0 = m_drop;
        for (int c = 0; c < 8; c++) begin
            step(syms[c] != 0, syms[c], qtys[c], 0, 0, '0, 0);
            n_checks += 3;
            if (bus.rpt_valid !== exp_rv) begin n_err++; $display("FAIL full rpt_valid cyc=%0d got=%b want=%b", c, bus.rpt_valid, exp_rv); end
            if (exp_rv && (bus.rpt_position !== 16'(exp_rpos) || bus.rpt_slot !== 2'(exp_rslot) || bus.rpt_symbol !== exp_rsym))
                begin n_err++; $display("FAIL full report cyc=%0d got=%0d/%0d want=%0d/%0d", c, $signed(bus.rpt_position), bus.rpt_slot, exp_rpos, exp_rslot); end
            if (bus.used_slots !== 3'(m_used)) begin n_err++; $display("FAIL full used_slots got=%0d want=%0d", bus.used_slots, m_used); end
        end
        n_checks += 3;
        if (bus.drop_count !== 32'(drop0 + 1)) begin n_err++; $display("FAIL full drop_count got=%0d want=%0d", bus.drop_count, drop0 + 1); end
        if (bus.table_full !== 1'b1) begin n_err++; $display("FAIL full table_full got=%b want=1", bus.table_full); end
        if (m_pos[1] != 17 || bus.rpt_position !== 16'd17) begin n_err++; $display("FAIL full sym2 position got=%0d want=17", $signed(bus.rpt_position)); end
    endtask

    task automatic test_breach();
        int qty [5] = '{150, 300, 150, 0, 0};
        bit sd  [5] = '{0, 1, 0, 0, 0};
        longint wpos [3] = '{150, -150, 0};
        bit     wbr  [3] = '{1, 1, 0};
        longint br0;
        int k = 0;
        step(0, '0, 0, 0, 0, '0, 1);
        bus.pos_limit = 15'd100;
        br0 = m_brc;
        for (int c = 0; c < 5; c++) begin
            step(c < 3, 16'h00B2, qty[c], sd[c], 0, '0, 0);
            if (exp_rv) begin
                n_checks += 3;
                if (bus.rpt_position !== 16'(wpos[k])) begin n_err++; $display("FAIL breach position got=%0d want=%0d", $signed(bus.rpt_position), wpos[k]); end
                if (bus.rpt_breach !== wbr[k]) begin n_err++; $display("FAIL breach flag got=%b want=%b", bus.rpt_breach, wbr[k]); end
                if (bus.breach_count !== 32'(m_brc)) begin n_err++; $display("FAIL breach count got=%0d want=%0d", bus.breach_count, m_brc); end
                k++;
            end
        end
        n_checks++;
        if (bus.breach_count !== 32'(br0 + 2)) begin n_err++; $display("FAIL breach total got=%0d want=%0d", bus.breach_count, br0 + 2); end
        bus.pos_limit = 15'd1000;
    endtask

    task automatic test_saturation();
        int qty [6] = '{30000, 30000, 65535, 65535, 0, 0};
        bit sd  [6] = '{0, 0, 1, 1, 0, 0};
        longint wpos [4] = '{30000, 32767, -32767, -32767};
        int k = 0;
        step(0, '0, 0, 0, 0, '0, 1);
        for (int c = 0; c < 6; c++) begin
            step(c < 4, 16'h00D4, qty[c], sd[c], 0, '0, 0);
            if (exp_rv) begin
                n_checks++;
                if (bus.rpt_position !== 16'(wpos[k])) begin n_err++; $display("FAIL saturate position step=%0d got=%0d want=%0d", k, $signed(bus.rpt_position), wpos[k]); end
                k++;
            end
        end
    endtask

    task automatic test_reclaim_clear();
        int want_used;
`ifdef POSITION_LEDGER_ZERO_RECLAIM_EN
        want_used = 0;
`else
        want_used = 1;
`endif
        step(0, '0, 0, 0, 0, '0, 1);
        step(1, 16'h00C3, 10, 0, 0, '0, 0);
        step(1, 16'h00C3, 10, 1, 0, '0, 0);
        step(0, '0, 0, 0, 0, '0, 0);
        n_checks += 2;
        if (bus.rpt_valid !== 1'b1 || bus.rpt_position !== '0) begin n_err++; $display("FAIL reclaim report got=%b/%0d want=1/0", bus.rpt_valid, $signed(bus.rpt_position)); end
        step(0, '0, 0, 0, 0, '0, 0);
        if (bus.used_slots !== 3'(want_used)) begin n_err++; $display("FAIL reclaim used_slots got=%0d want=%0d", bus.used_slots, want_used); end
        step(1, 16'h00C3, 5, 0, 1, 16'h00C3, 0);
        step(1, 16'h00C3, 5, 0, 1, 16'h00C3, 1);
        for (int c = 0; c < 2; c++) begin
            step(0, '0, 0, 0, 0, '0, 0);
            n_checks += 2;
            if (bus.rpt_valid !== 1'b0) begin n_err++; $display("FAIL clear rpt_valid cyc=%0d got=%b want=0", c, bus.rpt_valid); end
            if (bus.used_slots !== '0) begin n_err++; $display("FAIL clear used_slots got=%0d want=0", bus.used_slots); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 19) == 0) bus.pos_limit = 15'($urandom_range(0, 32767));
            step($urandom_range(0, 3) != 0, 16'($urandom_range(1, 6)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 200)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(1, 7)),
                 $urandom_range(0, 39) == 0);
            n_checks += 6;
            if (bus.rpt_valid !== exp_rv) begin n_err++; $display("FAIL rand rpt_valid cyc=%0d got=%b want=%b", c, bus.rpt_valid, exp_rv); end
            if (exp_rv && (bus.rpt_symbol !== exp_rsym || bus.rpt_position !== 16'(exp_rpos) ||
                           bus.rpt_slot !== 2'(exp_rslot) || bus.rpt_breach !== exp_rbr))
                begin n_err++; $display("FAIL rand report cyc=%0d got=%h/%0d/%0d/%b want=%h/%0d/%0d/%b", c, bus.rpt_symbol, $signed(bus.rpt_position), bus.rpt_slot, bus.rpt_breach, exp_rsym, exp_rpos, exp_rslot, exp_rbr); end
            if (bus.qry_resp_valid !== exp_qv) begin n_err++; $display("FAIL rand qry_resp_valid cyc=%0d got=%b want=%b", c, bus.qry_resp_valid, exp_qv); end
            if (exp_qv && (bus.qry_found !== exp_qf || bus.qry_position !== 16'(exp_qp)))
                begin n_err++; $display("FAIL rand query cyc=%0d got=%b/%0d want=%b/%0d", c, bus.qry_found, $signed(bus.qry_position), exp_qf, exp_qp); end
            if (bus.used_slots !== 3'(m_used) || bus.table_full !== (m_used == NS))
                begin n_err++; $display("FAIL rand occupancy cyc=%0d got=%0d/%b want=%0d/%b", c, bus.used_slots, bus.table_full, m_used, m_used == NS); end
            if (bus.drop_count !== 32'(m_drop) || bus.breach_count !== 32'(m_brc))
                begin n_err++; $display("FAIL rand counters cyc=%0d got=%0d/%0d want=%0d/%0d", c, bus.drop_count, bus.breach_count, m_drop, m_brc); end
        end
    endtask

    task automatic test_reset_mid();
        step(1, 16'h00E5, 40, 0, 1, 16'h00E5, 0);
        bus.upd_valid = 0; bus.qry_valid = 0;
        #2 rst_n = 0;
        model_reset();
        #1;
        n_checks += 4;
        if (bus.rpt_valid !== 1'b0 || bus.qry_resp_valid !== 1'b0) begin n_err++; $display("FAIL midreset strobes got=%b/%b want=0/0", bus.rpt_valid, bus.qry_resp_valid); end
        if (bus.used_slots !== '0 || bus.table_full !== 1'b0) begin n_err++; $display("FAIL midreset occupancy got=%0d/%b want=0/0", bus.used_slots, bus.table_full); end
        if (bus.drop_count !== '0 || bus.breach_count !== '0) begin n_err++; $display("FAIL midreset counters got=%0d/%0d want=0/0", bus.drop_count, bus.breach_count); end
        if (bus.rpt_position !== '0 || bus.qry_position !== '0) begin n_err++; $display("FAIL midreset data got=%0d/%0d want=0/0", bus.rpt_position, bus.qry_position); end
        #3 rst_n = 1;
        for (int c = 0; c < 2; c++) begin
            step(0, '0, 0, 0, 0, '0, 0);
            n_checks++;
            if (bus.rpt_valid !== 1'b0) begin n_err++; $display("FAIL midreset inflight cyc=%0d got=%b want=0", c, bus.rpt_valid); end
        end
        step(0, '0, 0, 0, 1, 16'h00E5, 0);
        n_checks++;
        if (bus.qry_found !== 1'b0) begin n_err++; $display("FAIL midreset table got found=%b want=0", bus.qry_found); end
    endtask

    initial begin
        test_reset();
        test_accumulation();
        test_query_timing();
        test_table_full();
        test_breach();
        test_saturation();
        test_reclaim_clear();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
